// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: multi-precision adder/subtractor that walks an
// NWORDS*WIDTH-bit operand pair one WIDTH-bit slice per clock, LSB slice first,
// through a carry-select slice adder.
//
// Parameters:
//   WIDTH  - slice width handled per cycle (default 32)
//   NWORDS - number of slices per operand, legal range 2..16 (default 4)
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - asynchronous active-high reset
//   start     - request a new operation, sampled only while idle
//   op_sub    - 0 = a+b, 1 = a-b (captured with start)
//   a, b      - operands (captured with start)
//   busy      - high while running and during the done cycle
//   done      - one-cycle pulse, result valid
//   result    - sum/difference, modulo 2^(NWORDS*WIDTH); partial while busy
//   carry_out - final carry; for subtract 1 means no borrow
//   overflow  - signed overflow, only present when ADDSEQ_OVF_EN is defined
//
// Configuration macro: ADDSEQ_OVF_EN (adds the overflow port and its logic).

module mp_addsub_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [NWORDS*WIDTH-1:0]   a,
  input  logic [NWORDS*WIDTH-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic [NWORDS*WIDTH-1:0]   result,
  output logic                      carry_out
`ifdef ADDSEQ_OVF_EN
  ,
  output logic                      overflow
`endif
);

  localparam int unsigned Total = NWORDS * WIDTH;
  localparam int unsigned CntW  = $clog2(NWORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [Total-1:0]  r_a;
  logic [Total-1:0]  r_b;
  logic              r_sub;
  logic              r_carry;
  logic [Total-1:0]  r_result;
  logic              r_carry_out;
  logic              r_busy;
  logic              r_done;
`ifdef ADDSEQ_OVF_EN
  logic              r_overflow;
`endif

  logic [WIDTH-1:0]  w_a_sl;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin;
  logic [WIDTH:0]    w_path0;
  logic [WIDTH:0]    w_path1;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic              w_last;
  logic [31:0]       w_base;

  // Slice datapath: both carry-in outcomes are computed in parallel and the
  // actual carry-in just picks one, so no adder is wider than a slice.
  always_comb begin
    w_base  = 32'(r_cnt) * WIDTH;
    w_a_sl  = r_a[w_base +: WIDTH];
    w_b_eff = r_b[w_base +: WIDTH] ^ {WIDTH{r_sub}};
    w_cin   = (r_cnt == '0) ? r_sub : r_carry;
    w_path0 = {1'b0, w_a_sl} + {1'b0, w_b_eff};
    w_path1 = {1'b0, w_a_sl} + {1'b0, w_b_eff} + (WIDTH+1)'(1);
    if (w_cin) begin
      w_sum  = w_path1[WIDTH-1:0];
      w_cout = w_path1[WIDTH];
    end else begin
      w_sum  = w_path0[WIDTH-1:0];
      w_cout = w_path0[WIDTH];
    end
    w_last  = (r_cnt == LastCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef ADDSEQ_OVF_EN
      r_overflow  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= op_sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          // Slices land in place so the partial result is visible while busy.
          r_result[w_base +: WIDTH] <= w_sum;
          r_carry                   <= w_cout;
          if (w_last) begin
            r_carry_out <= w_cout;
`ifdef ADDSEQ_OVF_EN
            // Operand signs agree but the result sign differs.
            r_overflow  <= (r_a[Total-1] == (r_b[Total-1] ^ r_sub)) &&
                           (w_sum[WIDTH-1] != r_a[Total-1]);
`endif
            r_cnt       <= '0;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
`ifdef ADDSEQ_OVF_EN
  assign overflow  = r_overflow;
`endif

endmodule

// File: tb/tb_mp_addsub_seq.sv
// tb_mp_addsub_seq: directed-vector bench for mp_addsub_seq at WIDTH=8,
// NWORDS=4. Expected values are hand-computed constants. Overflow is checked
// only when ADDSEQ_OVF_EN is defined for the build.

module tb_mp_addsub_seq;

  localparam int unsigned Width  = 8;
  localparam int unsigned Nwords = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
`ifdef ADDSEQ_OVF_EN
  logic        overflow;
`endif

  int n_cmp;
  int n_err;

  mp_addsub_seq #(
    .WIDTH  (Width),
    .NWORDS (Nwords)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef ADDSEQ_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the
  // edge that ends the done cycle.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic sub, input logic [31:0] er, input logic ec,
                        input logic eo);
    int lat;
    a      = ta;
    b      = tb_v;
    op_sub = sub;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (done) break;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(Nwords));
    check_val({tag, "_res"}, 64'(result), 64'(er));
    check_val({tag, "_cout"}, 64'(carry_out), 64'(ec));
`ifdef ADDSEQ_OVF_EN
    check_val({tag, "_ovf"}, 64'(overflow), 64'(eo));
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
    @(posedge clk);
    #1;
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_val({tag, "_idle"}, 64'(busy), 64'd0);
    check_val({tag, "_hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    int ndone;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    #2;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_res", 64'(result), 64'd0);
    check_val("rst_cout", 64'(carry_out), 64'd0);
`ifdef ADDSEQ_OVF_EN
    check_val("rst_ovf", 64'(overflow), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("sovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub",    32'h1234_5678, 32'h0102_0304, 1'b1, 32'h1132_5374, 1'b1, 1'b0);

    // start held high with fresh operands through RUN and DONE.
    a      = 32'h0102_0304;
    b      = 32'h1020_3040;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    a     = 32'hAAAA_AAAA;
    b     = 32'h5555_5555;
    ndone = 0;
    for (int k = 1; k <= Nwords + 1; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        check_val("hold_res1", 64'(result), 64'h1122_3344);
        check_val("hold_lat1", 64'(k), 64'(Nwords));
      end
    end
    check_val("hold_ndone", 64'(ndone), 64'd1);
    check_val("hold_idle", 64'(busy), 64'd0);
    // Still high in IDLE, so the second op is taken at this edge.
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("hold_busy2", 64'(busy), 64'd1);
    ndone = 0;
    for (int k = 1; k <= Nwords + 1; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        check_val("hold_res2", 64'(result), 64'hFFFF_FFFF);
        check_val("hold_cout2", 64'(carry_out), 64'd0);
      end
    end
    check_val("hold_ndone2", 64'(ndone), 64'd1);

    // Leave a nonzero result and carry_out=1 so the reset clear is visible.
    run_op("precarry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    a      = 32'h1111_1111;
    b      = 32'h2222_2222;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_partial", 64'(result), 64'h0000_0033);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_done", 64'(done), 64'd0);
    check_val("mid_rst_res", 64'(result), 64'd0);
    check_val("mid_rst_cout", 64'(carry_out), 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_val("mid_rst_nodone", 64'(ndone), 64'd0);
    run_op("post_rst", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
